reg_file_wb: RTL and testbench

- 32-entry general-purpose register file that sits directly downstream of the ALU adder.
- Consumes the adder's 32-bit result and overflow flag at writeback and supplies both operand buses back to the adder.
- Applies MIPS-style arithmetic-overflow write suppression: a trapping add/sub that overflows does not update its destination.
- Latches an overflow exception record (sticky flag, faulting register index, 8-bit saturating count) for the control unit.

---
 rtl/reg_file_wb.sv | 85 ++++++++
 tb/tb_reg_file_wb.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/reg_file_wb.sv
// 32-entry register file at ALU writeback. Trapping add/sub that overflows does not write,
// and the trap is latched into a sticky exception record with a saturating count.
module reg_file_wb #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    rs_addr,
    input  logic [AW-1:0]    rt_addr,
    output logic [WIDTH-1:0] rs_data,
    output logic [WIDTH-1:0] rt_data,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic             trap_en,
    input  logic             over,
    output logic             ov_exc,
    output logic             ov_sticky,
    output logic [AW-1:0]    ov_reg,
    output logic [CNT_W-1:0] ov_count,
    input  logic             ov_clr
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic             r_sticky;
    logic [AW-1:0]    r_ov_reg;
    logic [CNT_W-1:0] r_count;

    logic             w_exc;
    logic             w_wr;

    assign w_exc = we & trap_en & over;
    // Committed write: also gates the read bypass, so a suppressed write is never forwarded.
    assign w_wr  = we & ~w_exc & (wa != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_regs <= '{default: '0};
        end else if (w_wr) begin
            r_regs[wa] <= wd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky <= 1'b0;
            r_ov_reg <= '0;
            r_count  <= '0;
        end else if (ov_clr) begin
            r_sticky <= 1'b0;
            r_ov_reg <= '0;
            r_count  <= '0;
        end else if (w_exc) begin
            r_sticky <= 1'b1;
            r_ov_reg <= wa;
            if (r_count != '1) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        rs_data = '0;
        if (rs_addr != '0) begin
            rs_data = (w_wr && (wa == rs_addr)) ? wd : r_regs[rs_addr];
        end
    end

    always_comb begin
        rt_data = '0;
        if (rt_addr != '0) begin
            rt_data = (w_wr && (wa == rt_addr)) ? wd : r_regs[rt_addr];
        end
    end

    assign ov_exc    = w_exc;
    assign ov_sticky = r_sticky;
    assign ov_reg    = r_ov_reg;
    assign ov_count  = r_count;

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed bench for reg_file_wb: bypass, r0, overflow suppression, saturation and clear.
module tb_reg_file_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs_addr, rt_addr, wa;
    logic [31:0] rs_data, rt_data, wd;
    logic        we, trap_en, over, ov_exc, ov_sticky, ov_clr;
    logic [4:0]  ov_reg;
    logic [7:0]  ov_count;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    reg_file_wb #(.WIDTH(32), .AW(5), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data),
        .we(we), .wa(wa), .wd(wd),
        .trap_en(trap_en), .over(over),
        .ov_exc(ov_exc), .ov_sticky(ov_sticky),
        .ov_reg(ov_reg), .ov_count(ov_count),
        .ov_clr(ov_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        we = 1'b0; wa = '0; wd = '0; trap_en = 1'b0; over = 1'b0; ov_clr = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; rs_addr = 5'd9; rt_addr = 5'd0;
        idle();
        #2;
        chk("rst_rs", rs_data, 32'h0);
        chk("rst_sticky", 32'(ov_sticky), 32'h0);
        chk("rst_reg", 32'(ov_reg), 32'h0);
        chk("rst_count", 32'(ov_count), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // reg5 written, then asynchronous reset mid-cycle
        we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
        step();
        idle(); rs_addr = 5'd5;
        #1 chk("r5_written", rs_data, 32'hDEADBEEF);
        #1 rst = 1'b1;
        #1 chk("r5_async_rst", rs_data, 32'h0);
        chk("cnt_async_rst", 32'(ov_count), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // write-through bypass on both ports, then array read
        we = 1'b1; wa = 5'd7; wd = 32'h12345678; rs_addr = 5'd7; rt_addr = 5'd7;
        #1 chk("bypass_rs", rs_data, 32'h12345678);
        chk("bypass_rt", rt_data, 32'h12345678);
        chk("bypass_exc", 32'(ov_exc), 32'h0);
        step();
        idle();
        #1 chk("r7_array", rs_data, 32'h12345678);

        // register 0 ignores writes
        we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; rs_addr = 5'd0;
        #1 chk("r0_same", rs_data, 32'h0);
        step();
        idle();
        #1 chk("r0_next", rs_data, 32'h0);

        // trap suppression
        we = 1'b1; wa = 5'd3; wd = 32'h11111111;
        step();
        we = 1'b1; wa = 5'd3; wd = 32'h80000000; trap_en = 1'b1; over = 1'b1; rs_addr = 5'd3;
        #1 chk("trap_exc", 32'(ov_exc), 32'h1);
        chk("trap_nobypass", rs_data, 32'h11111111);
        step();
        idle();
        #1 chk("trap_r3_kept", rs_data, 32'h11111111);
        chk("trap_sticky", 32'(ov_sticky), 32'h1);
        chk("trap_reg", 32'(ov_reg), 32'h3);
        chk("trap_count", 32'(ov_count), 32'h1);

        // trap flags without we do not raise ov_exc
        trap_en = 1'b1; over = 1'b1;
        #1 chk("nowe_exc", 32'(ov_exc), 32'h0);
        step();
        chk("nowe_count", 32'(ov_count), 32'h1);
        idle();

        // unsigned overflow writes normally
        we = 1'b1; wa = 5'd4; wd = 32'h00000001; over = 1'b1; rt_addr = 5'd4;
        #1 chk("uns_exc", 32'(ov_exc), 32'h0);
        chk("uns_bypass", rt_data, 32'h1);
        step();
        idle();
        #1 chk("uns_r4", rt_data, 32'h1);
        chk("uns_count", 32'(ov_count), 32'h1);

        // trap targeting r0 still records index 0
        we = 1'b1; wa = 5'd0; wd = 32'h5; trap_en = 1'b1; over = 1'b1;
        #1 chk("r0trap_exc", 32'(ov_exc), 32'h1);
        step();
        idle();
        #1 chk("r0trap_reg", 32'(ov_reg), 32'h0);
        chk("r0trap_count", 32'(ov_count), 32'h2);

        // saturation: 300 trap cycles on r3
        we = 1'b1; wa = 5'd3; trap_en = 1'b1; over = 1'b1; rs_addr = 5'd3;
        for (int i = 0; i < 300; i++) begin
            wd = $urandom;
            step();
            if (i == 9) chk("sat_mid_count", 32'(ov_count), 32'd12);
        end
        chk("sat_count", 32'(ov_count), 32'd255);
        chk("sat_reg", 32'(ov_reg), 32'h3);
        chk("sat_r3_kept", rs_data, 32'h11111111);

        // clear wins over a simultaneous trap, write still suppressed
        ov_clr = 1'b1; wd = 32'h0;
        #1 chk("clr_exc", 32'(ov_exc), 32'h1);
        step();
        idle();
        #1 chk("clr_count", 32'(ov_count), 32'h0);
        chk("clr_sticky", 32'(ov_sticky), 32'h0);
        chk("clr_reg", 32'(ov_reg), 32'h0);
        chk("clr_r3_kept", rs_data, 32'h11111111);

        // counting restarts after clear
        we = 1'b1; wa = 5'd6; trap_en = 1'b1; over = 1'b1;
        step();
        idle();
        #1 chk("post_clr_count", 32'(ov_count), 32'h1);
        chk("post_clr_reg", 32'(ov_reg), 32'h6);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
